// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: reference-function
// encodings, FSM state encodings and the reference gate model.
package gate_chk_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_AND  = 2'b00;
  localparam op_t OP_OR   = 2'b01;
  localparam op_t OP_XOR  = 2'b10;
  localparam op_t OP_NAND = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Widest gate the checker supports; narrower vectors are zero-extended
  // and only the low n bits take part in the reduction.
  localparam int MAX_IN = 8;

  function automatic logic ref_gate(input op_t op, input logic [MAX_IN-1:0] v,
                                    input int n);
    logic all_ones;
    logic any_one;
    logic parity;
    logic result;
    all_ones = 1'b1;
    any_one  = 1'b0;
    parity   = 1'b0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < n) begin
        all_ones = all_ones & v[i];
        any_one  = any_one | v[i];
        parity   = parity ^ v[i];
      end
    end
    case (op)
      OP_AND:  result = all_ones;
      OP_OR:   result = any_one;
      OP_XOR:  result = parity;
      default: result = ~all_ones;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gate_delay_line.sv
// Fixed-latency pipeline that carries {vector, valid} alongside the gate
// under test so each vector meets its own response. DEPTH=0 is a wire.
module gate_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stage [DEPTH];

      // Shift every cycle; a flush drops all in-flight entries so a restarted
      // run never sees vectors from the run it replaced.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (flush) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = DEPTH - 1; i > 0; i--) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/gate_resp_checker.sv
// Self-checker for a combinational gate under test: realigns each applied
// vector with the gate output, compares against a reference reduction,
// counts mismatches, keeps the first failing vector and tracks coverage.
module gate_resp_checker
  import gate_chk_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int LAT   = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [N_IN-1:0]  vec,
  input  logic             vec_valid,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid,
  output logic             cov_full
);

  localparam int COV_W      = 2 ** N_IN;
  localparam int DRAIN_LAST = (LAT > 0) ? LAT - 1 : 0;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              seen;
  logic [2:0]        drain_cnt;
  op_t               op_q;
  logic              line_valid_in;
  logic [N_IN:0]     line_in;
  logic [N_IN:0]     line_out;
  logic [N_IN-1:0]   d_vec;
  logic              d_valid;
  logic [MAX_IN-1:0] vec_ext;
  logic              exp_y;
  logic              cmp_en;
  logic              mismatch;
  logic [COV_W-1:0]  cov_map;

  // Only vectors applied during RUN enter the pipeline; a start cycle
  // belongs to neither the old nor the new run.
  assign line_valid_in = vec_valid & (state == ST_RUN) & ~start;
  assign line_in       = {vec, line_valid_in};

  gate_delay_line #(
    .W     (N_IN + 1),
    .DEPTH (LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start),
    .din   (line_in),
    .dout  (line_out)
  );

  assign d_vec   = line_out[N_IN:1];
  assign d_valid = line_out[0];

  // Expected gate output for the vector now emerging from the pipeline.
  always_comb begin
    vec_ext            = '0;
    vec_ext[N_IN-1:0]  = d_vec;
    exp_y              = ref_gate(op_q, vec_ext, N_IN);
  end

  assign cmp_en   = d_valid & ((state == ST_RUN) | (state == ST_DRAIN)) & ~start;
  assign mismatch = cmp_en & (dut_y != exp_y);

  // Next-state decode; start from any state (re)arms a run.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (!vec_valid && seen) state_next = ST_DRAIN;
        ST_DRAIN: if (drain_cnt == 3'(DRAIN_LAST)) state_next = ST_DONE;
        default:  state_next = state;
      endcase
    end
  end

  // Run control: state, drain timer, latched op and the status flags.
  // pass is taken on DONE entry, after the final compare has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seen      <= 1'b0;
      drain_cnt <= '0;
      op_q      <= OP_AND;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_RUN) | (state_next == ST_DRAIN);
      if (start) begin
        op_q      <= op_sel;
        seen      <= 1'b0;
        drain_cnt <= '0;
        done      <= 1'b0;
        pass      <= 1'b0;
      end else begin
        if (state == ST_RUN && vec_valid) seen <= 1'b1;
        if (state == ST_DRAIN) drain_cnt <= drain_cnt + 3'd1;
        else                   drain_cnt <= '0;
        if (state == ST_DRAIN && state_next == ST_DONE) begin
          done <= 1'b1;
          pass <= (err_cnt == '0) & (&cov_map);
        end
      end
    end
  end

  // Scoreboard: saturating error count, first failing vector, coverage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      cov_map         <= '0;
      cov_full        <= 1'b0;
    end else if (start) begin
      err_cnt         <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
      cov_map         <= '0;
      cov_full        <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
        if (!first_err_valid) begin
          first_err_vec   <= d_vec;
          first_err_valid <= 1'b1;
        end
      end
      if (cmp_en) cov_map[d_vec] <= 1'b1;
      cov_full <= &cov_map;
    end
  end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed and randomized bench for gate_resp_checker; each run's expected
// results come from a behavioural model of the whole vector list.
module tb_gate_resp_checker;

  localparam int N_IN    = 2;
  localparam int LAT     = 1;
  localparam int ERR_W   = 8;
  localparam int NV      = 1 << N_IN;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op_sel = 2'b00;
  logic [N_IN-1:0]  vec = '0;
  logic             vec_valid = 1'b0;
  logic             dut_y = 1'b0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [N_IN-1:0]  first_err_vec;
  logic             first_err_valid;
  logic             cov_full;

  int checks = 0;
  int errors = 0;

  logic [N_IN-1:0] vec_q[$];
  logic            y_q[$];

  gate_resp_checker #(
    .N_IN  (N_IN),
    .LAT   (LAT),
    .ERR_W (ERR_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .op_sel          (op_sel),
    .vec             (vec),
    .vec_valid       (vec_valid),
    .dut_y           (dut_y),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_err_vec   (first_err_vec),
    .first_err_valid (first_err_valid),
    .cov_full        (cov_full)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference gate defined by counting ones in the vector.
  function automatic logic model_gate(input logic [1:0] op, input logic [N_IN-1:0] v);
    int ones;
    ones = $countones(v);
    case (op)
      2'b00:   return ones == N_IN;
      2'b01:   return ones > 0;
      2'b10:   return (ones % 2) == 1;
      default: return ones != N_IN;
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " pass"}, pass, 0);
    checkOutput({tag, " err_cnt"}, err_cnt, 0);
    checkOutput({tag, " first_err_vec"}, first_err_vec, 0);
    checkOutput({tag, " first_err_valid"}, first_err_valid, 0);
    checkOutput({tag, " cov_full"}, cov_full, 0);
  endtask

  // Plays vec_q through the checker (dut_y for vector i arrives LAT cycles
  // after it), waits for done, then checks against the whole-run model.
  task automatic applyStimulus(input logic [1:0] op, input bit do_start, input string tag);
    int  n;
    int  cycles;
    int  errs;
    int  exp_lat;
    bit  covered [NV];
    bit  all_cov;
    logic first_valid;
    logic [N_IN-1:0] first_vec;
    n = vec_q.size();
    cycles = 0;
    if (do_start) begin
      op_sel    = op;
      start     = 1'b1;
      vec_valid = 1'b0;
      tick();
      start = 1'b0;
    end
    for (int i = 0; i < n + LAT; i++) begin
      vec_valid = (i < n);
      vec       = (i < n) ? vec_q[i] : N_IN'($urandom_range(0, NV - 1));
      dut_y     = (i >= LAT) ? y_q[i-LAT] : 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    vec_valid = 1'b0;
    for (int k = 0; k < 16 && done !== 1'b1; k++) begin
      tick();
      cycles++;
    end
    errs = 0;
    first_valid = 1'b0;
    first_vec = '0;
    for (int v = 0; v < NV; v++) covered[v] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (y_q[i] !== model_gate(op, vec_q[i])) begin
        if (!first_valid) first_vec = vec_q[i];
        first_valid = 1'b1;
        errs++;
      end
      covered[vec_q[i]] = 1'b1;
    end
    all_cov = 1'b1;
    for (int v = 0; v < NV; v++) all_cov = all_cov & covered[v];
    // Last vector, one gap cycle, then at least one drain cycle.
    exp_lat = n + 1 + ((LAT > 0) ? LAT : 1);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " latency"}, cycles, exp_lat);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " err_cnt"}, err_cnt, (errs > ERR_MAX) ? ERR_MAX : errs);
    checkOutput({tag, " first_err_valid"}, first_err_valid, first_valid);
    checkOutput({tag, " first_err_vec"}, first_err_vec, first_vec);
    checkOutput({tag, " cov_full"}, cov_full, all_cov);
    checkOutput({tag, " pass"}, pass, (errs == 0) && all_cov);
    tick();
    checkOutput({tag, " done_held"}, done, 1);
  endtask

  task automatic loadCorrect(input logic [1:0] op);
    y_q.delete();
    foreach (vec_q[i]) y_q.push_back(model_gate(op, vec_q[i]));
  endtask

  initial begin
    int n;
    logic [1:0] op;

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (2) tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick();

    $display("[TB] OR, all vectors, clean");
    vec_q = '{2'b00, 2'b01, 2'b10, 2'b11};
    loadCorrect(2'b01);
    applyStimulus(2'b01, 1'b1, "or_clean");

    $display("[TB] OR, vector 10 answered wrong");
    loadCorrect(2'b01);
    y_q[2] = 1'b0;
    applyStimulus(2'b01, 1'b1, "or_err");

    $display("[TB] AND, partial coverage");
    vec_q = '{2'b00, 2'b01, 2'b11};
    loadCorrect(2'b00);
    applyStimulus(2'b00, 1'b1, "and_partial");

    $display("[TB] XOR, output stuck at 1, saturation");
    vec_q.delete();
    vec_q.push_back(2'b01);
    vec_q.push_back(2'b10);
    for (int i = 0; i < 298; i++) vec_q.push_back($urandom_range(0, 1) ? 2'b11 : 2'b00);
    y_q.delete();
    foreach (vec_q[i]) y_q.push_back(1'b1);
    applyStimulus(2'b10, 1'b1, "xor_sat");

    $display("[TB] restart with an error in flight");
    op_sel = 2'b01;
    start = 1'b1;
    vec_valid = 1'b0;
    tick();
    start = 1'b0;
    vec = 2'b01; vec_valid = 1'b1; dut_y = 1'b0;
    tick();
    vec = 2'b10; vec_valid = 1'b1; dut_y = 1'b1;
    tick();
    start = 1'b1; vec_valid = 1'b0; dut_y = 1'b0;
    tick();
    start = 1'b0;
    checkOutput("restart err_cnt", err_cnt, 0);
    checkOutput("restart first_err_valid", first_err_valid, 0);
    checkOutput("restart busy", busy, 1);
    vec_q = '{2'b11, 2'b00, 2'b01, 2'b10};
    loadCorrect(2'b01);
    applyStimulus(2'b01, 1'b0, "restart_run");

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      op = 2'($urandom_range(0, 3));
      n  = $urandom_range(1, 12);
      vec_q.delete();
      y_q.delete();
      for (int i = 0; i < n; i++) begin
        vec_q.push_back(N_IN'($urandom_range(0, NV - 1)));
        y_q.push_back(model_gate(op, vec_q[i]) ^ ($urandom_range(0, 3) == 0));
      end
      applyStimulus(op, 1'b1, $sformatf("rand%0d", r));
    end

    $display("[TB] asynchronous reset mid-run");
    op_sel = 2'b01;
    start = 1'b1;
    vec_valid = 1'b0;
    tick();
    start = 1'b0;
    vec = 2'b00; vec_valid = 1'b1; dut_y = 1'b0;
    tick();
    vec = 2'b01; vec_valid = 1'b1; dut_y = 1'b1;
    tick();
    checkOutput("pre_reset err_cnt", err_cnt, 1);
    checkOutput("pre_reset busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      vec = N_IN'($urandom_range(0, NV - 1));
      vec_valid = 1'b1;
      dut_y = 1'($urandom_range(0, 1));
      tick();
    end
    vec_valid = 1'b0;
    tick();
    checkAllZero("post_reset_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
